// File: rtl/rsa_operand_loader_pkg.sv
// Shared definitions for the RSA operand loader: default width, operand select
// codes and handshake FSM states.
package rsa_operand_loader_pkg;

  localparam int BITS_DEF = 128;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    SEL_M    = 2'd0,
    SEL_E    = 2'd1,
    SEL_N    = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_GO    = 3'd2,
    ST_ARM   = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/rsa_operand_reg.sv
// One operand register: byte-wide left shift on write, clear, and a byte count
// that saturates at the number of bytes in the operand.
module rsa_operand_reg
  import rsa_operand_loader_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             clr_en,
  input  logic [7:0]       sw,
  output logic [BITS-1:0]  op,
  output logic [CNT_W-1:0] cnt
);

  localparam int NBYTE = BITS / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTE);

  logic [BITS-1:0]  op_q,  op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next operand value and count; clear wins over write.
  always_comb begin
    op_d  = op_q;
    cnt_d = cnt_q;
    if (clr_en) begin
      op_d  = {BITS{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else if (wr_en) begin
      op_d = {op_q[BITS-9:0], sw};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 5'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      op_d  = op_q;
      cnt_d = cnt_q;
    end
  end

  // Operand and count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q  <= {BITS{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  assign op  = op_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/rsa_operand_loader.sv
// Loads M/E/N from switch bytes, validates N, issues a one-cycle go to the
// Montgomery exponentiator and latches its result on done.
module rsa_operand_loader
  import rsa_operand_loader_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       sw,
  input  logic [1:0]       sel,
  input  logic             wr,
  input  logic             clr,
  input  logic             start,
  input  logic             exp_done,
  input  logic [BITS-1:0]  exp_result,
  output logic [BITS-1:0]  m_out,
  output logic [BITS-1:0]  e_out,
  output logic [BITS-1:0]  n_out,
  output logic             exp_go,
  output logic [BITS-1:0]  result,
  output logic             result_valid,
  output logic             busy,
  output logic             err,
  output logic [4:0]       byte_cnt
);

  state_e          state_q, state_d;
  logic [BITS-1:0] result_q, result_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;
  logic            go_q, go_d;
  logic            busy_q, busy_d;

  logic             idle_s;
  logic [CNT_W-1:0] m_cnt_s, e_cnt_s, n_cnt_s;

  assign idle_s = (state_q == ST_IDLE);

  rsa_operand_reg #(.BITS(BITS)) u_m (
    .clock (clock), .reset (reset),
    .wr_en (wr  & idle_s & (sel == SEL_M)),
    .clr_en(clr & idle_s & (sel == SEL_M)),
    .sw    (sw), .op (m_out), .cnt (m_cnt_s)
  );

  rsa_operand_reg #(.BITS(BITS)) u_e (
    .clock (clock), .reset (reset),
    .wr_en (wr  & idle_s & (sel == SEL_E)),
    .clr_en(clr & idle_s & (sel == SEL_E)),
    .sw    (sw), .op (e_out), .cnt (e_cnt_s)
  );

  rsa_operand_reg #(.BITS(BITS)) u_n (
    .clock (clock), .reset (reset),
    .wr_en (wr  & idle_s & (sel == SEL_N)),
    .clr_en(clr & idle_s & (sel == SEL_N)),
    .sw    (sw), .op (n_out), .cnt (n_cnt_s)
  );

  // Byte count of the currently selected operand.
  always_comb begin
    byte_cnt = 5'd0;
    case (sel)
      SEL_M:   byte_cnt = m_cnt_s;
      SEL_E:   byte_cnt = e_cnt_s;
      SEL_N:   byte_cnt = n_cnt_s;
      default: byte_cnt = 5'd0;
    endcase
  end

  // Handshake FSM. ARM refuses to proceed while a stale done from the
  // previous run is still high, so WAIT only ever sees this run's done edge.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rv_d     = rv_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CHECK;
        else       state_d = ST_IDLE;
      end
      ST_CHECK: begin
        if (n_out[0] == 1'b0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d   = 1'b0;
          rv_d    = 1'b0;
          state_d = ST_GO;
        end
      end
      ST_GO: state_d = ST_ARM;
      ST_ARM: begin
        if (exp_done == 1'b0) state_d = ST_WAIT;
        else                  state_d = ST_ARM;
      end
      ST_WAIT: begin
        if (exp_done == 1'b1) begin
          result_d = exp_result;
          rv_d     = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    go_d   = (state_d == ST_GO);
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= {BITS{1'b0}};
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
    end
  end

  assign exp_go       = go_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Scoreboard bench for rsa_operand_loader with a behavioural exponentiator
// that holds done high until several cycles after the next go.
module tb_rsa_operand_loader;

  localparam int BITS = 128;
  localparam int LAT  = 50;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       sw    = 8'h00;
  logic [1:0]       sel   = 2'd0;
  logic             wr    = 1'b0;
  logic             clr   = 1'b0;
  logic             start = 1'b0;
  logic             exp_done   = 1'b0;
  logic [BITS-1:0]  exp_result = '0;
  logic [BITS-1:0]  m_out, e_out, n_out, result;
  logic             exp_go, result_valid, busy, err;
  logic [4:0]       byte_cnt;

  int checks = 0;
  int errors = 0;
  int go_count = 0;
  int go_mark = 0;
  int tmr = 0;
  int drop = 0;
  logic [BITS-1:0] mdl_val = '0;
  logic [BITS-1:0] sb_q[$];
  logic [BITS-1:0] n_exp;

  rsa_operand_loader #(.BITS(BITS)) dut (
    .clock(clock), .reset(reset), .sw(sw), .sel(sel), .wr(wr), .clr(clr),
    .start(start), .exp_done(exp_done), .exp_result(exp_result),
    .m_out(m_out), .e_out(e_out), .n_out(n_out), .exp_go(exp_go),
    .result(result), .result_valid(result_valid), .busy(busy), .err(err),
    .byte_cnt(byte_cnt)
  );

  always #5 clock = ~clock;

  function automatic longint unsigned modexp(input longint unsigned b,
                                             input longint unsigned e,
                                             input longint unsigned n);
    longint unsigned r = 1 % n;
    b = b % n;
    while (e > 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r;
  endfunction

  // Behavioural exponentiator: done falls 3 cycles after go, rises LAT cycles after go.
  always @(posedge clock) begin
    if (exp_go) begin
      go_count++;
      tmr     <= LAT;
      drop    <= 3;
      mdl_val <= BITS'(modexp(m_out[63:0], e_out[63:0], n_out[63:0]));
    end else begin
      if (drop > 0) begin
        drop <= drop - 1;
        if (drop == 1) exp_done <= 1'b0;
      end
      if (tmr > 0) begin
        tmr <= tmr - 1;
        if (tmr == 1) begin
          exp_done   <= 1'b1;
          exp_result <= mdl_val;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_byte(input logic [1:0] s, input logic [7:0] b);
    sel = s; sw = b; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic clr_op(input logic [1:0] s);
    sel = s; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Start a run expected to pass the modulus check; result pushed to scoreboard.
  task automatic start_valid(input logic [BITS-1:0] expv);
    start = 1'b1;
    tick();
    start = 1'b0; wr = 1'b0;
    chk("check_busy", BITS'(busy), BITS'(1'b1));
    chk("check_go_low", BITS'(exp_go), BITS'(1'b0));
    tick();
    chk("go_at_t2", BITS'(exp_go), BITS'(1'b1));
    chk("go_busy", BITS'(busy), BITS'(1'b1));
    chk("err_cleared", BITS'(err), BITS'(1'b0));
    chk("rv_cleared", BITS'(result_valid), BITS'(1'b0));
    go_mark = go_count;
    sb_q.push_back(expv);
  endtask

  task automatic wait_result();
    int  n = 0;
    logic busy_drop = 1'b0;
    while (!result_valid && n < 300) begin
      if (!busy) busy_drop = 1'b1;
      tick();
      n++;
    end
    chk("result_timeout", BITS'(result_valid), BITS'(1'b1));
    chk("busy_held", BITS'(busy_drop), BITS'(1'b0));
    chk("busy_after", BITS'(busy), BITS'(1'b0));
    chk("go_pulses", BITS'(go_count - go_mark), BITS'(1));
    if (sb_q.size() > 0) chk("result", result, sb_q.pop_front());
    else chk("sb_empty", BITS'(sb_q.size()), BITS'(1));
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_m", m_out, '0);
    chk("rst_n", n_out, '0);
    chk("rst_result", result, '0);
    chk("rst_flags", BITS'({exp_go, result_valid, busy, err}), BITS'(4'b0000));

    // Test 1: fill N with 01..10, then one more byte.
    n_exp = '0;
    for (int i = 1; i <= 16; i++) begin
      wr_byte(2'd2, 8'(i));
      n_exp = {n_exp[BITS-9:0], 8'(i)};
    end
    chk("n_fill", n_out, 128'h0102030405060708090A0B0C0D0E0F10);
    chk("n_fill_model", n_out, n_exp);
    chk("cnt_full", BITS'(byte_cnt), BITS'(16));
    wr_byte(2'd2, 8'h11);
    chk("n_shift17", n_out, 128'h02030405060708090A0B0C0D0E0F1011);
    chk("cnt_sat", BITS'(byte_cnt), BITS'(16));
    wr_byte(2'd3, 8'h55);
    chk("sel3_ignored", n_out, 128'h02030405060708090A0B0C0D0E0F1011);
    chk("sel3_cnt", BITS'(byte_cnt), BITS'(0));
    sel = 2'd2; clr = 1'b1; wr = 1'b1; sw = 8'hAA;
    tick();
    clr = 1'b0; wr = 1'b0;
    chk("clr_prio", n_out, '0);
    chk("clr_cnt", BITS'(byte_cnt), BITS'(0));

    // Test 2: 2^3 mod 11, N written in the same cycle as start.
    clr_op(2'd0); wr_byte(2'd0, 8'h02);
    clr_op(2'd1); wr_byte(2'd1, 8'h03);
    sel = 2'd2; sw = 8'h0B; wr = 1'b1;
    start_valid(128'd8);
    wait_result();
    chk("rv_set", BITS'(result_valid), BITS'(1'b1));

    // Test 3: even modulus rejected.
    clr_op(2'd2); wr_byte(2'd2, 8'h0A);
    go_mark = go_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("even_err", BITS'(err), BITS'(1'b1));
    chk("even_busy", BITS'(busy), BITS'(1'b0));
    for (int i = 0; i < 4; i++) tick();
    chk("even_no_go", BITS'(go_count - go_mark), BITS'(0));

    // Tests 4/5: 4^3 mod 13 with stale done high; writes/start ignored while busy.
    clr_op(2'd0); wr_byte(2'd0, 8'h04);
    clr_op(2'd2); wr_byte(2'd2, 8'h0D);
    start_valid(128'd12);
    for (int i = 0; i < 10; i++) tick();
    chk("stale_not_taken", BITS'(result_valid), BITS'(1'b0));
    sel = 2'd0; sw = 8'hFF; wr = 1'b1; start = 1'b1;
    tick();
    wr = 1'b0; start = 1'b0;
    chk("busy_wr_ignored", m_out, 128'd4);
    chk("busy_cnt", BITS'(byte_cnt), BITS'(1));
    wait_result();

    // Test 6: async reset during WAIT, then a normal run (3^5 mod 7).
    start_valid(128'd0);
    for (int i = 0; i < 10; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_ops", m_out | e_out | n_out | result, '0);
    chk("arst_flags", BITS'({exp_go, result_valid, busy, err, byte_cnt}), BITS'(0));
    #1 reset = 1'b0;
    sb_q.delete();
    tick();
    wr_byte(2'd0, 8'h03);
    wr_byte(2'd1, 8'h05);
    wr_byte(2'd2, 8'h07);
    start_valid(128'd5);
    wait_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
